fft_frame_packer: RTL
=====================

Name: fft_frame_packer

Overview:
- Read-side consumer of the prefetch FIFO in the audio FFT/FIR path.
- Pops samples through the FIFO's rd_vld/rd_en handshake and groups them into fixed-length frames for the FFT core.
- Output is a valid/ready stream with start-of-packet (sop) and end-of-packet (eop) markers.
- A flush request closes a partial frame by zero-padding it to full length.

Parameters:
DATA_W, 32, sample word width; equals the FIFO c_RD_DATA_WIDTH
FRAME_LEN_W, 10, width of the frame-length configuration; maximum frame is 2^FRAME_LEN_W samples
FCNT_W, 16, width of the completed-frame counter

Ports:
rd_clk  in  1  clock; the FIFO read clock
rd_rst  in  1  asynchronous active-high reset
fifo_rd_data  in  DATA_W  FIFO read data (prefetched)
fifo_rd_vld  in  1  FIFO output valid
fifo_rd_en  out  1  FIFO pop/ready; a beat transfers when fifo_rd_vld & fifo_rd_en
cfg_frame_len_m1  in  FRAME_LEN_W  frame length minus 1
flush  in  1  single-cycle request to pad the current partial frame
m_data  out  DATA_W  output sample
m_valid  out  1  output valid
m_ready  in  1  downstream ready
m_sop  out  1  first beat of a frame, qualified by m_valid
m_eop  out  1  last beat of a frame, qualified by m_valid
frame_cnt  out  FCNT_W  number of completed frames, wraps
busy  out  1  high in PASS or PAD

Behaviour:
- Clock and reset: one clock, rd_clk. Reset rd_rst is asynchronous and active-high.
- Reset values: m_valid=0, m_data=0, m_sop=0, m_eop=0, frame_cnt=0, busy=0, state=IDLE, sample counter=0, latched length=0.
- fifo_rd_en is forced to 0 while rd_rst is high.
- Output register: single stage. load = ~m_valid | m_ready.
  - On load, the register takes the new beat, or clears m_valid if no beat is produced.
  - m_data, m_sop and m_eop are held stable while m_valid & ~m_ready.
- Latency: a FIFO pop in cycle N appears on m_data with m_valid=1 in cycle N+1. No bubbles occur when both sides stream.
- fifo_rd_en = load in IDLE and PASS; 0 in PAD.
- pop = fifo_rd_vld & fifo_rd_en.
- States:
  - IDLE: no frame open.
    - On pop: emit the beat with m_sop=1; latch len=cfg_frame_len_m1; set cnt=1.
    - If cfg_frame_len_m1==0, also set m_eop=1 and stay in IDLE; otherwise go to PASS.
  - PASS: on pop, emit the beat with m_sop=0 and increment cnt.
    - If cnt==len, set m_eop=1, clear cnt and go to IDLE.
  - PAD: on each load, emit m_data=0 with m_valid=1; increment cnt.
    - The beat with cnt==len carries m_eop=1, then go to IDLE.
- flush:
  - Sampled only in PASS.
  - If the same cycle's pop completes the frame (eop), flush is ignored.
  - Otherwise any pop in that cycle still transfers and counts, and the next state is PAD.
  - flush in IDLE or PAD is ignored and not remembered.
- cfg_frame_len_m1 changes take effect only at the next sop; the open frame keeps its latched len.
- frame_cnt increments by 1 when a beat with m_eop=1 handshakes (m_valid & m_ready). It wraps from 2^FCNT_W-1 to 0.
- Counter width is FRAME_LEN_W+1 internally. cnt never exceeds len+1. len = all-ones produces 2^FRAME_LEN_W beats.
- Empty FIFO mid-frame (fifo_rd_vld=0): the frame stays open, no beats are emitted and the state is held. There is no timeout.
- Backpressure (m_ready=0 with m_valid=1): fifo_rd_en=0, so no pop occurs and no data is lost.
- Reset mid-frame: the partial frame is discarded immediately. The next frame starts with a sop on the first pop after release.

Test Plan:
- Stream test: cfg_frame_len_m1=7, FIFO preloaded with 16 words 0x00000001..0x00000010, m_ready=1.
  - Required: 16 consecutive output beats.
  - sop on values 0x01 and 0x09; eop on 0x08 and 0x10.
  - frame_cnt ends at 2; first m_valid one cycle after the first pop.
- Backpressure: same setup with m_ready toggling 1,0,0,1 repeating.
  - Required: output data sequence identical to the stream test.
  - m_data stable while stalled; fifo_rd_en=0 on every stalled cycle.
- Flush: cfg_frame_len_m1=7, 3 words 0xA1,0xA2,0xA3 pushed, flush pulsed after the third pop.
  - Required: beats 0xA1(sop), 0xA2, 0xA3, then five zero beats, the last with eop.
  - No FIFO pops during PAD; frame_cnt=1.
- Length 1: cfg_frame_len_m1=0, 4 words pushed.
  - Required: 4 beats, each with sop=1 and eop=1; frame_cnt=4.
- Config change mid-frame: cfg_frame_len_m1 switched from 3 to 1 after the second beat of a frame, with 8 words supplied.
  - Required: first frame has 4 beats; following frames have 2 beats.
- Reset mid-frame: assert rd_rst after 2 beats of a 4-beat frame.
  - Required: m_valid=0, frame_cnt=0, busy=0 immediately.
  - Next pushed word is emitted with sop=1.

Source files
------------

// File: rtl/fft_frame_packer.sv
// ---------------------------------------------------------------------------
// fft_frame_packer
//
// Read-side consumer of the prefetch FIFO feeding the audio FFT core. It pops
// samples through the FIFO valid/enable handshake and re-emits them as a
// valid/ready stream. The stream is cut into frames of (cfg_frame_len_m1 + 1)
// samples, with sop on the first beat and eop on the last beat of each frame.
// A flush pulse closes a partially filled frame by padding it with zero
// samples up to the latched frame length.
//
// Ports
//   rd_clk            FIFO read clock
//   rd_rst            asynchronous active-high reset
//   fifo_rd_data      prefetched FIFO read data
//   fifo_rd_vld       FIFO output valid
//   fifo_rd_en        FIFO pop; a word transfers on fifo_rd_vld & fifo_rd_en
//   cfg_frame_len_m1  frame length minus one, latched at each sop
//   flush             single-cycle request to pad the open frame
//   m_data/m_valid/m_ready  output stream
//   m_sop/m_eop       first/last beat of a frame, qualified by m_valid
//   frame_cnt         completed (eop handshaken) frames, wraps
//   busy              a frame is open (PASS or PAD)
// ---------------------------------------------------------------------------
module fft_frame_packer #(
  parameter int DATA_W      = 32,
  parameter int FRAME_LEN_W = 10,
  parameter int FCNT_W      = 16
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  input  logic [DATA_W-1:0]      fifo_rd_data,
  input  logic                   fifo_rd_vld,
  output logic                   fifo_rd_en,
  input  logic [FRAME_LEN_W-1:0] cfg_frame_len_m1,
  input  logic                   flush,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_sop,
  output logic                   m_eop,
  output logic [FCNT_W-1:0]      frame_cnt,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    PAD  = 2'd2
  } state_t;

  localparam logic [FRAME_LEN_W:0] CNT_ONE  = (FRAME_LEN_W+1)'(1);
  localparam logic [FCNT_W-1:0]    FCNT_ONE = FCNT_W'(1);

  state_t                 state, state_nxt;
  logic [FRAME_LEN_W:0]   cnt, cnt_nxt;
  logic [FRAME_LEN_W-1:0] len, len_nxt;
  logic [FRAME_LEN_W:0]   len_ext;
  logic                   load;
  logic                   rd_en_int;
  logic                   pop;
  logic                   cnt_last;

  // Beat presented to the output register this cycle.
  logic                   beat_vld_p0;
  logic [DATA_W-1:0]      beat_data_p0;
  logic                   beat_sop_p0;
  logic                   beat_eop_p0;

  // The output register can accept a new beat when empty or being drained.
  assign load      = ~m_valid | m_ready;
  // No pops while padding; rd_rst gates the enable combinationally so the
  // FIFO never loses a word during reset.
  assign rd_en_int = ~rd_rst & load & (state != PAD);
  assign fifo_rd_en = rd_en_int;
  assign pop       = fifo_rd_vld & rd_en_int;

  // cnt is one bit wider than len so len = all-ones still terminates.
  assign len_ext   = {1'b0, len};
  assign cnt_last  = (cnt == len_ext);
  assign busy      = (state != IDLE);

  // Next-state and beat generation
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    len_nxt      = len;
    beat_vld_p0  = 1'b0;
    beat_data_p0 = fifo_rd_data;
    beat_sop_p0  = 1'b0;
    beat_eop_p0  = 1'b0;

    case (state)
      IDLE: begin
        if (pop) begin
          beat_vld_p0 = 1'b1;
          beat_sop_p0 = 1'b1;
          len_nxt     = cfg_frame_len_m1;
          cnt_nxt     = CNT_ONE;
          if (cfg_frame_len_m1 == '0) begin
            // Single-sample frame: sop and eop on the same beat.
            beat_eop_p0 = 1'b1;
          end else begin
            state_nxt = PASS;
          end
        end
      end

      PASS: begin
        if (pop) begin
          beat_vld_p0 = 1'b1;
          if (cnt_last) begin
            beat_eop_p0 = 1'b1;
            cnt_nxt     = '0;
            state_nxt   = IDLE;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        // A flush that coincides with the frame's own eop has nothing left
        // to pad, so it is dropped.
        if (flush && !(pop && cnt_last)) begin
          state_nxt = PAD;
        end
      end

      PAD: begin
        if (load) begin
          beat_vld_p0  = 1'b1;
          beat_data_p0 = '0;
          if (cnt_last) begin
            beat_eop_p0 = 1'b1;
            cnt_nxt     = '0;
            state_nxt   = IDLE;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Frame control registers
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state <= IDLE;
      cnt   <= '0;
      len   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      len   <= len_nxt;
    end
  end

  // Output register stage (_p0 beat -> m_*); holds while stalled
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sop   <= 1'b0;
      m_eop   <= 1'b0;
    end else if (load) begin
      m_valid <= beat_vld_p0;
      if (beat_vld_p0) begin
        m_data <= beat_data_p0;
        m_sop  <= beat_sop_p0;
        m_eop  <= beat_eop_p0;
      end
    end
  end

  // Completed-frame counter, advanced when an eop beat is accepted
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      frame_cnt <= '0;
    end else if (m_valid && m_ready && m_eop) begin
      frame_cnt <= frame_cnt + FCNT_ONE;
    end
  end

endmodule
